// File: rtl/ram_port_arbiter_if.sv
// Requester-side bus for ram_port_arbiter: two valid/grant ports with read return.
// m0_lock exists only when ARB_LOCK_EN is defined.
interface ram_port_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              m0_req;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_gnt;
    logic [DATA_W-1:0] m0_rdata;
    logic              m0_rvalid;
    logic              m1_req;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_gnt;
    logic [DATA_W-1:0] m1_rdata;
    logic              m1_rvalid;
`ifdef ARB_LOCK_EN
    logic              m0_lock;
`endif

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_gnt, m0_rdata, m0_rvalid,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m1_gnt, m1_rdata, m1_rvalid
`ifdef ARB_LOCK_EN
        , output m0_lock
`endif
    );

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_gnt, m0_rdata, m0_rvalid,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m1_gnt, m1_rdata, m1_rvalid
`ifdef ARB_LOCK_EN
        , input m0_lock
`endif
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Two-port round-robin arbiter in front of RAM256x8 with registered strobes and read return.
// Optional ARB_LOCK_EN lets port 0 hold the RAM exclusively for read-modify-write.
module ram_port_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    ram_port_arbiter_if.slave bus,
    output logic              ram_n_cs,
    output logic              ram_n_oe,
    output logic              ram_n_we,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_in,
    input  logic [DATA_W-1:0] ram_data_out
);
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACCESS = 1'b1;

    logic [0:0]              state;
    logic                    last_gnt;
    logic                    rd_pend;
    logic                    rd_port;
    logic                    lock_hold;
    logic                    gnt0, gnt1, xfer;
    logic                    sel_we;
    logic [ADDR_W-1:0]       sel_addr;
    logic [DATA_W-1:0]       sel_wdata;
    logic [1:0][DATA_W-1:0]  rdata_q;
    logic [1:0]              rvalid_q;

`ifdef ARB_LOCK_EN
    logic lock_q;
    // Lock arms on a port 0 transfer with m0_lock high and releases the cycle after m0_lock drops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) lock_q <= 1'b0;
        else       lock_q <= lock_q ? bus.m0_lock : (gnt0 && bus.m0_lock);
    end
    assign lock_hold = lock_q;
`else
    assign lock_hold = 1'b0;
`endif

    // last_gnt = 1 means port 1 was granted most recently, so port 0 wins a tie.
    always_comb begin
        gnt0      = bus.m0_req && (lock_hold || !bus.m1_req || last_gnt);
        gnt1      = bus.m1_req && !lock_hold && (!bus.m0_req || !last_gnt);
        xfer      = gnt0 || gnt1;
        sel_we    = gnt1 ? bus.m1_we    : bus.m0_we;
        sel_addr  = gnt1 ? bus.m1_addr  : bus.m0_addr;
        sel_wdata = gnt1 ? bus.m1_wdata : bus.m0_wdata;
    end

    assign bus.m0_gnt    = gnt0;
    assign bus.m1_gnt    = gnt1;
    assign bus.m0_rdata  = rdata_q[0];
    assign bus.m1_rdata  = rdata_q[1];
    assign bus.m0_rvalid = rvalid_q[0];
    assign bus.m1_rvalid = rvalid_q[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            last_gnt    <= 1'b1;
            rd_pend     <= 1'b0;
            rd_port     <= 1'b0;
            ram_n_cs    <= 1'b1;
            ram_n_oe    <= 1'b1;
            ram_n_we    <= 1'b1;
            ram_address <= '0;
            ram_data_in <= '0;
            rdata_q     <= '0;
            rvalid_q    <= '0;
        end else begin
            state    <= xfer ? ACCESS : IDLE;
            ram_n_cs <= !xfer;
            ram_n_we <= !(xfer && sel_we);
            ram_n_oe <= !(xfer && !sel_we);
            rd_pend  <= xfer && !sel_we;
            if (xfer) begin
                ram_address <= sel_addr;
                last_gnt    <= gnt1;
                rd_port     <= gnt1;
                if (sel_we) ram_data_in <= sel_wdata;
            end
            // Read data is sampled at the end of the ACCESS cycle that drove n_oe low.
            rvalid_q <= '0;
            if (state == ACCESS && rd_pend) begin
                rvalid_q[rd_port] <= 1'b1;
                rdata_q[rd_port]  <= ram_data_out;
            end
        end
    end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: behavioural RAM, per-port request queues, spec-level model
// checked every cycle, plus literal expectations for the directed scenarios.
module tb_ram_port_arbiter;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ram_n_cs, ram_n_oe, ram_n_we;
    logic [7:0] ram_address, ram_data_in, ram_data_out;
    logic [7:0] ram [256];

    ram_port_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bif();

    ram_port_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk(clk), .reset(reset), .bus(bif),
        .ram_n_cs(ram_n_cs), .ram_n_oe(ram_n_oe), .ram_n_we(ram_n_we),
        .ram_address(ram_address), .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (!ram_n_cs && !ram_n_we) ram[ram_address] <= ram_data_in;
    assign ram_data_out = (!ram_n_cs && !ram_n_oe) ? ram[ram_address] : 8'h00;

    typedef struct { bit act; bit we; logic [7:0] addr; logic [7:0] wd; bit lock; } op_t;
    op_t q0[$];
    op_t q1[$];
    int  total = 0;
    int  bad = 0;
    bit  run = 0;
    int  g1cnt = 0;

    // Model state: what the DUT outputs must be during the current cycle.
    bit         e_acc, e_we, e_port;
    logic [7:0] e_addr, e_din;
    bit   [1:0] e_rv;
    logic [7:0] e_rd [2];
    bit         mlast, mlock;
    bit         cpend;
    logic [7:0] caddr, cdata;
    logic [7:0] mmem [256];
`ifdef ARB_LOCK_EN
    bit         lock0;
`endif

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push(input int p, input bit act, input bit we, input int a, input int d, input bit lk);
        op_t o;
        o.act = act; o.we = we; o.addr = a[7:0]; o.wd = d[7:0]; o.lock = lk;
        if (p == 0) q0.push_back(o); else q1.push_back(o);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        q0.delete(); q1.delete();
        bif.m0_req = 1'b0; bif.m1_req = 1'b0;
        e_acc = 0; e_we = 0; e_port = 0; e_addr = 8'h00; e_din = 8'h00;
        e_rv = 2'b00; e_rd[0] = 8'h00; e_rd[1] = 8'h00;
        mlast = 1; mlock = 0; cpend = 0;
    endtask

    // Driver: present each queue head until it is accepted; commit model writes at the edge.
    always @(posedge clk) begin
        #1;
        if (cpend) begin mmem[caddr] = cdata; cpend = 0; end
        if (q0.size() > 0) begin
            bif.m0_req = q0[0].act; bif.m0_we = q0[0].we; bif.m0_addr = q0[0].addr; bif.m0_wdata = q0[0].wd;
        end else bif.m0_req = 1'b0;
        if (q1.size() > 0) begin
            bif.m1_req = q1[0].act; bif.m1_we = q1[0].we; bif.m1_addr = q1[0].addr; bif.m1_wdata = q1[0].wd;
        end else bif.m1_req = 1'b0;
`ifdef ARB_LOCK_EN
        lock0 = (q0.size() > 0) ? q0[0].lock : 1'b0;
        bif.m0_lock = lock0;
`endif
    end

    // Compare process: check this cycle, then advance the model across the coming edge.
    always @(negedge clk) begin
        if (run && !reset) begin
            bit g0, g1;
            if (mlock)                        begin g0 = bif.m0_req; g1 = 0; end
            else if (bif.m0_req && bif.m1_req) begin g0 = mlast; g1 = !mlast; end
            else                              begin g0 = bif.m0_req; g1 = bif.m1_req; end
            chk("m0_gnt", bif.m0_gnt, g0);
            chk("m1_gnt", bif.m1_gnt, g1);
            chk("gnt_excl", bif.m0_gnt & bif.m1_gnt, 0);
            chk("n_cs", ram_n_cs, !e_acc);
            chk("n_we", ram_n_we, !(e_acc && e_we));
            chk("n_oe", ram_n_oe, !(e_acc && !e_we));
            if (e_acc) chk("ram_address", ram_address, e_addr);
            chk("ram_data_in", ram_data_in, e_din);
            chk("m0_rvalid", bif.m0_rvalid, e_rv[0]);
            chk("m1_rvalid", bif.m1_rvalid, e_rv[1]);
            chk("m0_rdata", bif.m0_rdata, e_rd[0]);
            chk("m1_rdata", bif.m1_rdata, e_rd[1]);
            if (bif.m1_gnt) g1cnt++;
            e_rv = 2'b00;
            if (e_acc && !e_we) begin e_rv[e_port] = 1; e_rd[e_port] = mmem[e_addr]; end
            if (e_acc && e_we) begin cpend = 1; caddr = e_addr; cdata = e_din; end
`ifdef ARB_LOCK_EN
            mlock = mlock ? lock0 : (g0 && lock0);
`endif
            e_acc = g0 || g1;
            if (e_acc) begin
                e_port = g1;
                mlast  = g1;
                e_we   = g1 ? bif.m1_we : bif.m0_we;
                e_addr = g1 ? bif.m1_addr : bif.m0_addr;
                if (e_we) e_din = g1 ? bif.m1_wdata : bif.m0_wdata;
            end
            if (q0.size() > 0 && (!q0[0].act || g0)) void'(q0.pop_front());
            if (q1.size() > 0 && (!q1[0].act || g1)) void'(q1.pop_front());
        end
    end

    task automatic nxt();
        @(negedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bif.m0_we = 0; bif.m0_addr = 0; bif.m0_wdata = 0;
        bif.m1_we = 0; bif.m1_addr = 0; bif.m1_wdata = 0;
`ifdef ARB_LOCK_EN
        bif.m0_lock = 0;
`endif
        do_reset();
        repeat (3) @(posedge clk);
        #3 reset = 1'b0; run = 1;
        nxt();
        chk("rst_n_cs", ram_n_cs, 1); chk("rst_n_oe", ram_n_oe, 1); chk("rst_n_we", ram_n_we, 1);
        chk("rst_addr", ram_address, 0); chk("rst_din", ram_data_in, 0);
        chk("rst_m0_rvalid", bif.m0_rvalid, 0); chk("rst_m1_rvalid", bif.m1_rvalid, 0);

        // Single write, then idle strobes
        push(0, 1, 1, 8'h10, 8'hA5, 0);
        nxt(); chk("t1_gnt", bif.m0_gnt, 1);
        nxt(); chk("t1_n_cs", ram_n_cs, 0); chk("t1_n_we", ram_n_we, 0); chk("t1_n_oe", ram_n_oe, 1);
               chk("t1_addr", ram_address, 8'h10); chk("t1_din", ram_data_in, 8'hA5);
        nxt(); chk("t1_idle_cs", ram_n_cs, 1); chk("t1_idle_we", ram_n_we, 1); chk("t1_idle_oe", ram_n_oe, 1);

        // Read back with two-edge latency
        push(0, 1, 0, 8'h10, 0, 0);
        nxt(); chk("t2_gnt", bif.m0_gnt, 1);
        nxt(); chk("t2_n_oe", ram_n_oe, 0); chk("t2_n_we", ram_n_we, 1);
        nxt(); chk("t2_rvalid", bif.m0_rvalid, 1); chk("t2_rdata", bif.m0_rdata, 8'hA5);
               chk("t2_m1_rvalid", bif.m1_rvalid, 0);
        nxt(); chk("t2_rvalid_pulse", bif.m0_rvalid, 0);

        // Read-after-write on consecutive transfers
        push(0, 1, 1, 8'h12, 8'h3C, 0);
        push(0, 1, 0, 8'h12, 0, 0);
        repeat (5) nxt();
        chk("raw_rdata", bif.m0_rdata, 8'h3C);

        // Port 1 alone: back-to-back writes (also preloads later scenarios)
        g1cnt = 0;
        push(1, 1, 1, 8'h20, 8'h11, 0); push(1, 1, 1, 8'h30, 8'h22, 0);
        push(1, 1, 1, 8'h70, 8'h33, 0); push(1, 1, 1, 8'h50, 8'h55, 0);
        push(1, 1, 1, 8'h60, 8'h66, 0);
        for (int i = 0; i < 4; i++) push(1, 1, 1, 8'h40 + i, 8'hC0 + i, 0);
        repeat (12) nxt();
        chk("t4_grants", g1cnt, 9);
        for (int i = 0; i < 4; i++) chk("t4_ram", ram[8'h40 + i], 8'hC0 + i);
        chk("t4_ram20", ram[8'h20], 8'h11);

        // Both ports continuously: alternate starting with port 0
        for (int i = 0; i < 3; i++) begin push(0, 1, 0, 8'h20, 0, 0); push(1, 1, 0, 8'h30, 0, 0); end
        nxt(); chk("t3_g0_a", bif.m0_gnt, 1); chk("t3_g1_a", bif.m1_gnt, 0);
        nxt(); chk("t3_g0_b", bif.m0_gnt, 0); chk("t3_g1_b", bif.m1_gnt, 1);
        nxt(); chk("t3_g0_c", bif.m0_gnt, 1); chk("t3_g1_c", bif.m1_gnt, 0);
        repeat (8) nxt();
        chk("t3_m0_rdata", bif.m0_rdata, 8'h11); chk("t3_m1_rdata", bif.m1_rdata, 8'h22);
        chk("t3_drained", q0.size() + q1.size(), 0);

        // Reset in the middle of a write ACCESS
        push(0, 1, 1, 8'h70, 8'h5A, 0);
        nxt(); nxt();
        do_reset();
        #1;
        chk("t5_n_cs", ram_n_cs, 1); chk("t5_n_we", ram_n_we, 1); chk("t5_n_oe", ram_n_oe, 1);
        chk("t5_m0_rvalid", bif.m0_rvalid, 0); chk("t5_m1_rvalid", bif.m1_rvalid, 0);
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        nxt();
        chk("t5_write_lost", ram[8'h70], 8'h33);
        push(0, 1, 0, 8'h20, 0, 0); push(1, 1, 0, 8'h30, 0, 0);
        nxt(); chk("t5_g0", bif.m0_gnt, 1); chk("t5_g1", bif.m1_gnt, 0);
        repeat (6) nxt();

`ifdef ARB_LOCK_EN
        // Locked read-modify-write: port 1 starved until lock drops
        push(0, 1, 0, 8'h50, 0, 1); push(0, 0, 0, 0, 0, 1); push(0, 0, 0, 0, 0, 1);
        push(0, 1, 1, 8'h50, 8'h77, 1);
        push(1, 1, 0, 8'h60, 0, 0);
        nxt(); chk("lk_g0_rd", bif.m0_gnt, 1); chk("lk_g1_0", bif.m1_gnt, 0);
        nxt(); chk("lk_g1_1", bif.m1_gnt, 0);
        nxt(); chk("lk_g1_2", bif.m1_gnt, 0);
        nxt(); chk("lk_g0_wr", bif.m0_gnt, 1); chk("lk_g1_3", bif.m1_gnt, 0);
        nxt(); chk("lk_g1_4", bif.m1_gnt, 0);
        nxt(); chk("lk_g1_rel", bif.m1_gnt, 1);
        repeat (4) nxt();
        chk("lk_ram50", ram[8'h50], 8'h77);
        chk("lk_m0_rdata", bif.m0_rdata, 8'h55);
        chk("lk_m1_rdata", bif.m1_rdata, 8'h66);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single RAM256x8 data memory between two requesters: port 0 (CPU datapath load/store) and port 1 (debug/program-loader).
- Accepts at most one access per clock using a valid/grant handshake and arbitrates round-robin when both ports request.
- Drives the RAM's active-low strobes (n_cs, n_oe, n_we) from registers, and returns registered read data with a valid pulse.
- Sits between the datapath and RAM256x8, replacing the direct Controller-to-RAM strobe wiring.

Parameters:
- ADDR_W, 8, RAM address width.
- DATA_W, 8, RAM data width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- m0_req  in  1  port 0 access request.
- m0_we  in  1  port 0: 1 = write, 0 = read.
- m0_addr  in  ADDR_W  port 0 address.
- m0_wdata  in  DATA_W  port 0 write data.
- m0_gnt  out  1  port 0 accepted this cycle (combinational).
- m0_rdata  out  DATA_W  port 0 read data.
- m0_rvalid  out  1  port 0 read data valid, one-cycle pulse.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rdata, m1_rvalid: same as port 0, for port 1.
- m0_lock  in  1  port 0 bus lock (only with ARB_LOCK_EN).
- ram_n_cs  out  1  RAM chip select, active low.
- ram_n_oe  out  1  RAM output enable, active low.
- ram_n_we  out  1  RAM write enable, active low.
- ram_address  out  ADDR_W  RAM address.
- ram_data_in  out  DATA_W  data to RAM.
- ram_data_out  in  DATA_W  data from RAM (combinational, valid while n_cs=0 and n_oe=0).

Behaviour:
- Reset (async):
  - ram_n_cs = ram_n_oe = ram_n_we = 1; ram_address = 0; ram_data_in = 0.
  - m*_rdata = 0; m*_rvalid = 0.
  - Pending access is discarded; the last-granted pointer is 1, so port 0 wins the first tie.
- Handshake:
  - A transfer occurs on a rising edge where req && gnt.
  - A requester holds req, we, addr and wdata stable until it samples gnt = 1. It may present the next request on the following cycle.
- Grant (combinational):
  - Only one port requesting: that port is granted.
  - Both requesting: the port not granted most recently wins. The pointer updates on each transfer.
  - No request: no grant.
  - Never both gnt high at once.
- Two states, based on a registered phase bit:
  - IDLE: strobes inactive.
  - ACCESS: strobes driven from the captured request.
  - On a transfer edge: ACCESS is entered (or stays) with the new request captured.
  - No transfer: return to IDLE.
  - Back-to-back transfers on consecutive cycles are allowed (throughput 1/cycle).
- ACCESS strobes:
  - Write: n_cs=0, n_oe=1, n_we=0, ram_address = addr, ram_data_in = wdata. The RAM commits on the next rising edge.
  - Read: n_cs=0, n_oe=0, n_we=1, ram_address = addr, ram_data_in unchanged.
- Read latency: accept at edge k; strobes are active during cycle k; at edge k+1 ram_data_out is registered into the owning port's rdata and that port's rvalid = 1 for one cycle.
  - rdata holds its value until the next read completes on that port.
  - A write never asserts rvalid.
- Read-after-write to the same address on consecutive transfers returns the new data.
- A requester deasserting req without a grant has no effect.
- Reset asserted during ACCESS deasserts the strobes immediately (async); a write not yet committed is lost.

Optional Feature:
- Macro: ARB_LOCK_EN.
- Defined:
  - m0_lock high while m0 holds the bus makes port 0 the sole grantee until m0_lock falls; m1_gnt stays 0 even if port 0 is idle.
  - The lock takes effect from the first port 0 transfer with m0_lock = 1.
  - Lock state is cleared by reset.
  - This supports atomic read-modify-write.
- Undefined: the m0_lock port is absent and arbitration is pure round-robin.

Test Plan:
- Reset, then port 0 writes 0xA5 to 0x10 → cycle after accept: ram_n_cs=0, ram_n_we=0, ram_n_oe=1, ram_address=0x10, ram_data_in=0xA5; next cycle all strobes = 1.
- Port 0 reads 0x10 on the cycle after that write → m0_rvalid=1 two edges after accept, m0_rdata=0xA5; m1_rvalid stays 0.
- Both ports request continuously, port 0 reading 0x20 and port 1 reading 0x30 (RAM preloaded 0x11/0x22) → grants alternate 0,1,0,1 starting with port 0; rdata 0x11 and 0x22 respectively; no cycle with both gnt high.
- Only port 1 requests 4 consecutive writes to 0x40..0x43 → 4 grants on consecutive cycles, 4 consecutive ACCESS cycles, RAM holds the data.
- Assert reset mid-ACCESS of a write → strobes go to 1 without a clock edge, m*_rvalid=0; the next simultaneous request is granted to port 0.
- (ARB_LOCK_EN) Port 0 with m0_lock=1 reads 0x50, idles 2 cycles, then writes 0x50 while m1_req is held high → m1_gnt=0 throughout; after m0_lock falls, m1 is granted on the next cycle.
